// File: rtl/ls74161_pc_pkg.sv
// Shared constants for the 74LS161-style program counter: slice width and slice count.
package ls74161_pc_pkg;

   localparam int unsigned SLICE_W = 4;

   function automatic int unsigned slice_count(input int unsigned width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/ls74161_pc_slice.sv
// One 4-bit synchronous binary counter slice modelled on the 74LS161.
module ls74161
   import ls74161_pc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_n,
   input  logic               enp,
   input  logic               ent,
   input  logic [SLICE_W-1:0] d,
   output logic [SLICE_W-1:0] q,
   output logic               rco
);

   logic [SLICE_W-1:0] cnt_q;
   logic [SLICE_W-1:0] cnt_d;

   // Load beats count; counting needs both enables.
   always_comb begin
      cnt_d = cnt_q;
      if (!load_n) begin
         cnt_d = d;
      end else if (enp && ent) begin
         cnt_d = cnt_q + SLICE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

   // Carry is independent of enp so a held all-ones value still signals terminal count.
   assign rco = ent && (cnt_q == '1);

endmodule

// File: rtl/ls74161_pc.sv
// Program counter built from WIDTH/4 cascaded ls74161 slices with a ripple enable-T chain.
module ls74161_pc
   import ls74161_pc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_n,
   input  logic             enp,
   input  logic             ent,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             rco
);

   localparam int unsigned N_SLICES = slice_count(WIDTH);

   // ent_chain[k] feeds slice k; ent_chain[k+1] is that slice's rco.
   logic [N_SLICES:0] ent_chain;

   assign ent_chain[0] = ent;

   for (genvar k = 0; k < N_SLICES; k++) begin : g_slice
      ls74161 u_slice (
         .clk    (clk),
         .rst_n  (rst_n),
         .load_n (load_n),
         .enp    (enp),
         .ent    (ent_chain[k]),
         .d      (d[k*SLICE_W +: SLICE_W]),
         .q      (q[k*SLICE_W +: SLICE_W]),
         .rco    (ent_chain[k+1])
      );
   end

   assign rco = ent_chain[N_SLICES];

endmodule

// File: tb/tb_ls74161_pc.sv
// Self-checking bench for ls74161_pc: vector table, hand-written reset sequences, random vs model.
module tb_ls74161_pc;

   localparam int unsigned WIDTH = 8;
   localparam int          MODV  = 256;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             load_n;
   logic             enp;
   logic             ent;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             rco;

   int n_tests = 0;
   int n_fail  = 0;
   int mq;

   typedef struct {
      logic             load_n;
      logic             enp;
      logic             ent;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] exp_q;
      logic             exp_rco;
      string            name;
   } vec_t;

   vec_t vecs[16];

   ls74161_pc #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_n (load_n),
      .enp    (enp),
      .ent    (ent),
      .d      (d),
      .q      (q),
      .rco    (rco)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [WIDTH-1:0] eq, input logic erco);
      n_tests++;
      if (q !== eq || rco !== erco) begin
         n_fail++;
         $display("FAIL %s: got q=%h rco=%b, expected q=%h rco=%b", name, q, rco, eq, erco);
      end
   endtask

   task automatic drive(input logic ld, input logic p, input logic t, input logic [WIDTH-1:0] dv);
      load_n = ld;
      enp    = p;
      ent    = t;
      d      = dv;
   endtask

   function automatic logic model_rco(input int v, input logic t);
      return t && (v == MODV - 1);
   endfunction

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0, "load_3c"};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, "hold_1"};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h3C, 1'b0, "hold_2"};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h55, 8'h3C, 1'b0, "hold_3"};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h0E, 8'h0E, 1'b0, "load_0e"};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h0F, 1'b0, "cnt_0f"};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h10, 1'b0, "nibble_carry_10"};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h11, 1'b0, "cnt_11"};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'hFE, 8'hFE, 1'b0, "load_fe"};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, "cnt_ff_rco"};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, "wrap_00"};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, "load_ff_ent0"};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, "ff_enp0_rco"};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, "ff_ent0_no_rco"};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 8'h7F, 8'h7F, 1'b0, "load_7f"};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h10, 8'h10, 1'b0, "load_beats_count"};

      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 8'h00);

      // Asynchronous reset between edges with a load pending.
      tick();
      drive(1'b0, 1'b0, 1'b0, 8'hA5);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", 8'h00, 1'b0);
      tick();
      chk("reset_holds_over_edge", 8'h00, 1'b0);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 8'h00);

      foreach (vecs[i]) begin
         drive(vecs[i].load_n, vecs[i].enp, vecs[i].ent, vecs[i].d);
         tick();
         chk(vecs[i].name, vecs[i].exp_q, vecs[i].exp_rco);
      end

      // Reset mid-count from 8'h20, then resume counting after release.
      drive(1'b0, 1'b0, 1'b0, 8'h20);
      tick();
      chk("load_20", 8'h20, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 8'h00);
      tick();
      chk("cnt_21", 8'h21, 1'b0);
      tick();
      chk("cnt_22", 8'h22, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk("mid_count_reset", 8'h00, 1'b0);
      tick();
      chk("reset_discards_count", 8'h00, 1'b0);
      #2 rst_n = 1'b1;
      tick();
      chk("first_edge_after_reset", 8'h01, 1'b0);

      // Randomized run against an arithmetic reference.
      mq = 1;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) != 0), WIDTH'($urandom_range(0, MODV - 1)));
         if ($urandom_range(0, 31) == 0) begin
            #2 rst_n = 1'b0;
            mq = 0;
            #1 chk("rand_reset", WIDTH'(mq), 1'b0);
            rst_n = 1'b1;
         end
         tick();
         if (!load_n) mq = int'(d);
         else if (enp && ent) mq = (mq + 1) % MODV;
         chk("random", WIDTH'(mq), model_rco(mq, ent));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
